// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

   localparam int unsigned DW_DEF = 16;
   localparam int unsigned VW_DEF = 8;
   localparam int unsigned CNT_W  = $clog2(DW_DEF);

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step: shift in one dividend bit, trial-subtract the divisor.
module div_restoring_step
   import div_pkg::*;
#(
   parameter int unsigned VW = VW_DEF
) (
   input  logic [VW-1:0] partial_rem,
   input  logic          dividend_bit,
   input  logic [VW-1:0] divisor,
   output logic [VW-1:0] partial_rem_next,
   output logic          q_bit
);

   logic [VW:0] trial;

   always_comb begin
      trial = {partial_rem, dividend_bit};
      q_bit = (trial >= {1'b0, divisor});
      // When the subtract succeeds, trial < 2*divisor, so the low VW bits of the difference are exact.
      partial_rem_next = q_bit ? (trial[VW-1:0] - divisor) : trial[VW-1:0];
   end

endmodule

// File: rtl/unsigned_16by8_seq_div.sv
// Sequential unsigned DW/VW restoring divider with valid/ready handshakes on both sides.
module unsigned_16by8_seq_div
   import div_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int unsigned CW = $clog2(DW);
   localparam logic [CW-1:0] LastCnt = CW'(DW - 1);

   div_state_t    state_q, state_d;
   logic [DW-1:0] sr_q;
   logic [VW-1:0] dvs_q;
   // The stored partial remainder is always < divisor, so its extra top bit is never kept.
   logic [VW-1:0] prem_q;
   logic [VW-1:0] prem_next;
   logic [CW-1:0] cnt_q;
   logic          q_bit;
   logic [DW-1:0] quotient_q;
   logic [VW-1:0] remainder_q;
   logic          dbz_q;

   div_restoring_step #(
      .VW(VW)
   ) u_step (
      .partial_rem      (prem_q),
      .dividend_bit     (sr_q[DW-1]),
      .divisor          (dvs_q),
      .partial_rem_next (prem_next),
      .q_bit            (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = (divisor == '0) ? DONE : RUN;
         RUN:     if (cnt_q == LastCnt) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q        <= '0;
         dvs_q       <= '0;
         prem_q      <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sr_q   <= dividend;
                  dvs_q  <= divisor;
                  prem_q <= '0;
                  cnt_q  <= '0;
                  if (divisor == '0) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend[VW-1:0];
                     dbz_q       <= 1'b1;
                  end
               end
            end
            RUN: begin
               sr_q   <= {sr_q[DW-2:0], q_bit};
               prem_q <= prem_next;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  quotient_q  <= {sr_q[DW-2:0], q_bit};
                  remainder_q <= prem_next;
                  dbz_q       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule
